ma_peak_detector: RTL and testbench

Consumes the aligned sample and dual moving-average stream produced by the moving-average stage, i.e. the delayed sample plus the long and short averages. It finds "blocks of interest", which are runs of steps where the short average exceeds the long average plus an offset. For each block of sufficient width it reports the maximum sample and that sample's index, then enforces a refractory window before the next detection. It sits directly downstream of the averaging filter and feeds the peak-event consumer.

---
 rtl/rpd_pkg.sv | 14 +
 rtl/ma_peak_detector.sv | 115 +++++++++++
 tb/tb_ma_peak_detector.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/rpd_pkg.sv
// Shared definitions for the moving-average / peak-detection chain:
// default data widths and the peak detector FSM encoding.
package rpd_pkg;

   localparam int RPD_DATA_WIDTH = 11;
   localparam int RPD_IDX_WIDTH  = 16;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_IN_BLOCK = 2'd1,
      ST_REFRACT  = 2'd2
   } rpd_state_e;

endpackage

// File: rtl/ma_peak_detector.sv
// Finds runs where the short average exceeds long average + offset and reports
// the earliest maximum sample of each sufficiently wide run, then holds off.
module ma_peak_detector
   import rpd_pkg::*;
#(
   parameter int                              DATA_WIDTH = RPD_DATA_WIDTH,
   parameter int                              IDX_WIDTH  = RPD_IDX_WIDTH,
   parameter int                              MIN_BLOCK  = 8,
   parameter int                              REFRACT    = 50,
   parameter logic signed [DATA_WIDTH-1:0]    OFFSET     = '0
) (
   input  logic                          i_clk,
   input  logic                          i_nrst,
   input  logic                          i_ce,
   input  logic signed [DATA_WIDTH-1:0]  i_sample,
   input  logic signed [DATA_WIDTH-1:0]  i_ma_long,
   input  logic signed [DATA_WIDTH-1:0]  i_ma_short,
   input  logic                          i_ma_valid,
   output logic                          o_peak_valid,
   output logic signed [DATA_WIDTH-1:0]  o_peak_amp,
   output logic [IDX_WIDTH-1:0]          o_peak_idx,
   output logic [1:0]                    o_state
);

   localparam int LEN_W = $clog2(MIN_BLOCK + 1);
   localparam int RC_W  = (REFRACT < 1) ? 1 : $clog2(REFRACT + 1);
   localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MIN_BLOCK);
   localparam logic [RC_W-1:0]  RC_INIT = RC_W'(REFRACT);

   rpd_state_e                   state_q, state_d;
   logic [IDX_WIDTH-1:0]         idx_q, max_idx_q;
   logic [LEN_W-1:0]             len_q;
   logic [RC_W-1:0]              rcnt_q;
   logic signed [DATA_WIDTH-1:0] max_q;
   logic                         step, drop, above, emit;

   // One extra bit keeps long + offset from wrapping.
   logic signed [DATA_WIDTH:0]   short_x, thr_x;
   assign short_x = (DATA_WIDTH+1)'(i_ma_short);
   assign thr_x   = (DATA_WIDTH+1)'(i_ma_long) + (DATA_WIDTH+1)'(OFFSET);
   assign above   = short_x > thr_x;

   assign step = i_ce & i_ma_valid;
   assign drop = i_ce & ~i_ma_valid;

   always_ff @(posedge i_clk or negedge i_nrst) begin
      if (!i_nrst) state_q <= ST_IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (drop) begin
         state_d = ST_IDLE;
      end else if (step) begin
         case (state_q)
            ST_IDLE:     if (above) state_d = ST_IN_BLOCK;
            ST_IN_BLOCK: if (!above) state_d = (emit && REFRACT != 0) ? ST_REFRACT : ST_IDLE;
            ST_REFRACT:  if (rcnt_q <= RC_W'(1)) state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      o_state = state_q;
      emit    = step && (state_q == ST_IN_BLOCK) && !above && (len_q >= LEN_MAX);
   end

   always_ff @(posedge i_clk or negedge i_nrst) begin
      if (!i_nrst) begin
         idx_q        <= '0;
         max_idx_q    <= '0;
         len_q        <= '0;
         rcnt_q       <= '0;
         max_q        <= '0;
         o_peak_valid <= 1'b0;
         o_peak_amp   <= '0;
         o_peak_idx   <= '0;
      end else begin
         // emit already requires i_ce, so the pulse self-clears when i_ce is low
         o_peak_valid <= emit;
         if (emit) begin
            o_peak_amp <= max_q;
            o_peak_idx <= max_idx_q;
         end
         if (drop) begin
            idx_q <= '0;
         end else if (step) begin
            idx_q <= idx_q + IDX_WIDTH'(1);
            case (state_q)
               ST_IDLE: if (above) begin
                  max_q     <= i_sample;
                  max_idx_q <= idx_q;
                  len_q     <= LEN_W'(1);
               end
               ST_IN_BLOCK: if (above) begin
                  if (len_q < LEN_MAX) len_q <= len_q + LEN_W'(1);
                  // strict compare keeps the earliest of equal maxima
                  if (i_sample > max_q) begin
                     max_q     <= i_sample;
                     max_idx_q <= idx_q;
                  end
               end
               default: ;
            endcase
            if (emit)
               rcnt_q <= RC_INIT;
            else if (state_q == ST_REFRACT && rcnt_q != '0)
               rcnt_q <= rcnt_q - RC_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_ma_peak_detector.sv
// Directed bench for ma_peak_detector (MIN_BLOCK=4, REFRACT=3, 4-bit index);
// expected events are queued by the stimulus and checked by a pulse monitor.
module tb_ma_peak_detector;

   localparam int DW = 11;
   localparam int IW = 4;

   logic                  i_clk = 1'b0;
   logic                  i_nrst = 1'b0;
   logic                  i_ce = 1'b0;
   logic                  i_ma_valid = 1'b0;
   logic signed [DW-1:0]  i_sample = '0;
   logic signed [DW-1:0]  i_ma_long = '0;
   logic signed [DW-1:0]  i_ma_short = '0;
   logic                  o_peak_valid;
   logic signed [DW-1:0]  o_peak_amp;
   logic [IW-1:0]         o_peak_idx;
   logic [1:0]            o_state;

   ma_peak_detector #(
      .DATA_WIDTH(DW), .IDX_WIDTH(IW), .MIN_BLOCK(4), .REFRACT(3), .OFFSET('0)
   ) dut (
      .i_clk(i_clk), .i_nrst(i_nrst), .i_ce(i_ce), .i_sample(i_sample),
      .i_ma_long(i_ma_long), .i_ma_short(i_ma_short), .i_ma_valid(i_ma_valid),
      .o_peak_valid(o_peak_valid), .o_peak_amp(o_peak_amp),
      .o_peak_idx(o_peak_idx), .o_state(o_state)
   );

   always #5 i_clk = ~i_clk;

   int cyc = 0;
   always @(posedge i_clk) cyc <= cyc + 1;

   typedef struct { int amp; int idx; int cyc; } exp_t;
   exp_t exp_q[$];
   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Short average is one above the long average when "above", equal otherwise,
   // so every non-above step also exercises the strict-greater boundary.
   task automatic drive(input bit ce, input bit vld, input bit abv, input int s);
      int l;
      @(negedge i_clk);
      l          = s / 2 - 7;
      i_ce       = ce;
      i_ma_valid = vld;
      i_sample   = DW'(s);
      i_ma_long  = DW'(l);
      i_ma_short = abv ? DW'(l + 1) : DW'(l);
   endtask

   task automatic step(input bit abv, input int s);
      drive(1'b1, 1'b1, abv, s);
   endtask

   task automatic term(input int amp, input int idx);
      step(1'b0, 0);
      exp_q.push_back('{amp, idx, cyc + 1});
   endtask

   task automatic hold_chk(input string nm, input int st);
      drive(1'b0, 1'b1, 1'b0, 0);
      chk(nm, int'(o_state), st);
   endtask

   initial begin : monitor
      forever begin
         @(negedge i_clk);
         if (i_nrst && o_peak_valid) begin
            exp_t e;
            if (exp_q.size() == 0) begin
               chk("unexpected_pulse", 1, 0);
            end else begin
               e = exp_q.pop_front();
               chk("peak_amp", int'(o_peak_amp), e.amp);
               chk("peak_idx", int'(o_peak_idx), e.idx);
               chk("peak_latency", cyc, e.cyc);
            end
         end
      end
   end

   initial begin : stim
      int b1[6];
      b1 = '{5, 9, 20, 7, 20, 3};

      repeat (3) @(negedge i_clk);
      chk("rst_valid", int'(o_peak_valid), 0);
      chk("rst_amp",   int'(o_peak_amp), 0);
      chk("rst_idx",   int'(o_peak_idx), 0);
      chk("rst_state", int'(o_state), 0);
      i_nrst = 1'b1;

      // basic block: steps 10..15 above, earliest max 20 at index 12
      for (int i = 0; i < 10; i++) step(1'b0, i);
      for (int i = 0; i < 6; i++) step(1'b1, b1[i]);
      term(20, 12);                       // step 16 -> idx 0
      hold_chk("refract_state", 2);

      // refractory: +1..+3 ignored, block opens at +4 (idx 4)
      repeat (3) step(1'b1, 100);
      hold_chk("refract_done", 0);
      step(1'b1, 30);
      hold_chk("block_open", 1);
      step(1'b1, 40); step(1'b1, 35); step(1'b1, 40); step(1'b1, 10);
      term(40, 5);                        // idx 9
      repeat (3) step(1'b0, 0);           // idx 10..12

      // short block (3 steps) gives no event
      repeat (3) step(1'b1, 50);          // idx 13..15
      step(1'b0, 0);                      // idx 0
      hold_chk("short_idle", 0);

      // valid drop mid-block, index restarts at 0
      step(1'b1, 60); step(1'b1, 61); step(1'b1, 62);   // idx 1..3
      drive(1'b1, 1'b0, 1'b0, 0);
      hold_chk("drop_idle", 0);
      step(1'b1, 7); step(1'b1, 8); step(1'b1, 9); step(1'b1, 6);  // idx 0..3
      term(9, 2);                         // idx 4
      repeat (3) step(1'b0, 0);           // idx 5..7

      // clock enable low freezes everything, block exactly MIN_BLOCK long
      step(1'b1, 3); step(1'b1, 70);      // idx 8, 9
      for (int i = 0; i < 5; i++) begin
         drive(1'b0, i[0], 1'b1, 127);
         chk("ce_freeze_state", int'(o_state), 1);
      end
      step(1'b1, 4); step(1'b1, 5);       // idx 10, 11
      term(70, 9);                        // idx 12
      repeat (3) step(1'b0, 0);           // idx 13..15

      // index wrap: max at 15, block spans 15 -> 0
      repeat (12) step(1'b0, 0);          // idx 0..11
      step(1'b1, 1); step(1'b1, 2); step(1'b1, 3);   // idx 12..14
      step(1'b1, 90); step(1'b1, 90); step(1'b1, 4); // idx 15, 0, 1
      term(90, 15);                       // idx 2
      repeat (3) step(1'b0, 0);           // idx 3..5

      // async reset mid-block, off the clock edge
      for (int i = 0; i < 5; i++) step(1'b1, 10 + i);
      @(negedge i_clk);
      i_ce = 1'b0;
      #2 i_nrst = 1'b0;
      #1;
      chk("arst_state", int'(o_state), 0);
      chk("arst_amp",   int'(o_peak_amp), 0);
      chk("arst_idx",   int'(o_peak_idx), 0);
      chk("arst_valid", int'(o_peak_valid), 0);
      @(negedge i_clk);
      i_nrst = 1'b1;
      step(1'b1, 5); step(1'b1, 8); step(1'b1, 8); step(1'b1, 2);  // idx 0..3
      term(8, 1);

      repeat (5) drive(1'b0, 1'b1, 1'b0, 0);
      chk("events_drained", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
